im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Write-side counterpart of the instruction memory read port. Accepts a byte
//  stream (valid/ready), assembles big-endian 32-bit instruction words and
//  writes them sequentially from word address 0 into the instruction store.
//  Sits between the host/UART byte source and the IM write port; holds the
//  CPU off (busy) while a program image is loaded.
// PARAMETERS
//  ADDR_W   10    word-address width (matches IM addr[11:2])
//  DEPTH    1024  IM depth in words; max accepted image length
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  start        in   1       1-cycle pulse: begin a new image load
//  in_valid     in   1       byte source has in_data
//  in_data      in   8       stream byte
//  in_ready     out  1       loader accepts a byte this cycle
//  mem_we       out  1       IM write strobe, 1 cycle per word
//  mem_addr     out  ADDR_W  IM word address (byte address [11:2])
//  mem_wdata    out  32      instruction word to write
//  busy         out  1       load in progress; CPU must be held off
//  done         out  1       sticky: image fully written
//  err          out  1       sticky: illegal length header
//  words_loaded out  ADDR_W+1 count of words written this load
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (in_ready, mem_we, mem_addr, mem_wdata,
//   busy, done, err, words_loaded). Reset mid-load aborts at that edge; words
//   already written stay in IM; no further mem_we.
//  Byte handshake: byte accepted on a rising edge with in_valid & in_ready.
//   in_ready=1 only in LEN_HI, LEN_LO, COLLECT; 0 in IDLE, WRITE, DONE.
//  Stream format: 16-bit big-endian word count N, then 4*N bytes; each word
//   big-endian (first byte -> [31:24], fourth -> [7:0]).
//  States:
//   IDLE:    start -> LEN_HI; clears done, err, words_loaded; busy=1.
//   LEN_HI:  accept byte -> len[15:8]; -> LEN_LO.
//   LEN_LO:  accept byte -> len[7:0]; if N==0 or N>DEPTH: err=1, busy=0,
//            -> IDLE; else byte_cnt=0, word_idx=0, -> COLLECT.
//   COLLECT: accept bytes into shift register; on 4th accepted byte -> WRITE.
//   WRITE:   mem_we=1 for exactly this cycle, mem_addr=word_idx,
//            mem_wdata=assembled word; words_loaded++ at end of cycle;
//            if word_idx==N-1 -> DONE else word_idx++, -> COLLECT.
//   DONE:    done=1, busy=0; start -> LEN_HI (clears done, busy=1).
//  Latency: mem_we asserts the cycle after the 4th byte handshake; peak
//   throughput 4 bytes per 5 cycles.
//  start while busy (any state but IDLE/DONE) is ignored.
//  mem_addr/mem_wdata hold last written values while mem_we=0.
//  word_idx never wraps: N<=DEPTH guarantees last address DEPTH-1.
//  in_valid gaps: loader waits indefinitely in LEN_*/COLLECT; no timeout.
//  Bytes offered in IDLE/DONE are not accepted (in_ready=0).
// TESTING
//  1 start; bytes 00 02 | 20 08 00 05 | 8C 09 00 00 -> mem_we at addr 0 data
//    0x20080005, then addr 1 data 0x8C090000; done=1, words_loaded=2, err=0.
//  2 header 00 00 -> err=1, done=0, busy=0, no mem_we; header 04 01 (1025)
//    -> err=1 likewise.
//  3 N=1 with in_valid toggled every other cycle -> exactly one mem_we, data
//    intact, mem_we one cycle after 4th accepted byte.
//  4 rst asserted after 6 of 8 data bytes -> next cycle all outputs 0, state
//    IDLE; later start + full 1-word image loads to addr 0 correctly.
//  5 N=1024 random image -> 1024 writes, addresses 0..1023 in order, last
//    addr 1023, words_loaded=1024, done=1; start pulses during load ignored.
//  6 in_valid held high in IDLE/DONE/WRITE -> in_ready=0, no byte consumed.

Source files
------------

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// master is the loader side; slave is the byte source / IM side.
interface im_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Loads a length-prefixed big-endian byte stream into the instruction memory,
// one 32-bit word per write, starting at word address 0.
module im_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  im_loader_if.master     bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_COLLECT, S_WRITE, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [15:0]       len;
  logic [23:0]       shift;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [15:0]       len_n;
  logic              accept, start_load, len_bad, last_word;

  assign accept     = bus.in_valid & bus.in_ready;
  assign start_load = start & ((state == S_IDLE) || (state == S_DONE));
  assign len_n      = {len[15:8], bus.in_data};
  assign len_bad    = (len_n == 16'd0) || (17'(len_n) > 17'(DEPTH));
  assign last_word  = (16'(word_idx) == (len - 16'd1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_LEN_HI;
      S_LEN_HI: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (bus.in_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (bus.in_valid) state_next = len_bad ? S_IDLE : S_COLLECT;
      end
      S_COLLECT: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (bus.in_valid && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: if (start) state_next = S_LEN_HI;
      default: state_next = S_IDLE;
    endcase
  end

  // Address/data are captured with the 4th byte so they hold after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      len          <= '0;
      shift        <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (start_load) begin
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
      end
      case (state)
        S_LEN_HI: if (accept) len[15:8] <= bus.in_data;
        S_LEN_LO: if (accept) begin
          len[7:0] <= bus.in_data;
          if (len_bad) begin
            err <= 1'b1;
          end else begin
            byte_cnt <= '0;
            word_idx <= '0;
          end
        end
        S_COLLECT: if (accept) begin
          shift    <= {shift[15:0], bus.in_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            bus.mem_addr  <= word_idx;
            bus.mem_wdata <= {shift, bus.in_data};
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          if (last_word) done <= 1'b1;
          else           word_idx <= word_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table of image loads, reset abort,
// throttled source, and a full-depth random image, with a write scoreboard.
module tb_im_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [15:0]   n;
    logic [31:0]   w0;
    logic [31:0]   w1;
    logic          exp_err;
    logic          exp_done;
    logic [ADDR_W:0] exp_words;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, err;
  logic [ADDR_W:0] words_loaded;

  int checks = 0;
  int errors = 0;
  wr_t sb[$];
  logic [31:0] img [DEPTH];
  vec_t vecs [6];

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every mem_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %08h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready %b, required 1", bus.in_ready);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic load_image(input logic [15:0] n_hdr, input int n_send,
                            input bit gap, input bit poke);
    pulse_start();
    send_byte(n_hdr[15:8], gap);
    send_byte(n_hdr[7:0], gap);
    for (int w = 0; w < n_send; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) sb.push_back('{addr: ADDR_W'(w), data: img[w]});
        if (poke && b == 1 && (w % 97) == 3) start = 1'b1;
        send_byte(img[w][31-8*b -: 8], gap);
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic hold_valid(input logic [ADDR_W:0] wl);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      check("ready_low_idle_done", 64'(bus.in_ready), 64'd0);
    end
    check("words_held", 64'(words_loaded), 64'(wl));
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0002, 32'h2008_0005, 32'h8C09_0000, 1'b0, 1'b1, 11'd2};
    vecs[1] = '{16'h0000, 32'h0,         32'h0,         1'b1, 1'b0, 11'd0};
    vecs[2] = '{16'h0401, 32'h0,         32'h0,         1'b1, 1'b0, 11'd0};
    vecs[3] = '{16'h0001, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 11'd1};
    vecs[4] = '{16'hFFFF, 32'h0,         32'h0,         1'b1, 1'b0, 11'd0};
    vecs[5] = '{16'h0002, 32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b1, 11'd2};

    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    hold_valid(11'd0);

    // Table of image loads, including length-header boundaries.
    for (int i = 0; i < 6; i++) begin
      img[0] = vecs[i].w0;
      img[1] = vecs[i].w1;
      load_image(vecs[i].n, vecs[i].exp_err ? 0 : int'(vecs[i].n), 1'b0, 1'b0);
      if (!vecs[i].exp_err) begin
        check("we_one_cycle_after_4th_byte", 64'(bus.mem_we), 64'd1);
        check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
      end
      wait_idle();
      check("err", 64'(err), 64'(vecs[i].exp_err));
      check("done", 64'(done), 64'(vecs[i].exp_done));
      check("words_loaded", 64'(words_loaded), 64'(vecs[i].exp_words));
      if (!vecs[i].exp_err) begin
        check("addr_hold", 64'(bus.mem_addr), 64'(vecs[i].n - 16'd1));
        check("data_hold", 64'(bus.mem_wdata),
              64'((vecs[i].n == 16'd1) ? vecs[i].w0 : vecs[i].w1));
      end
      hold_valid(vecs[i].exp_words);
    end

    // Throttled source: in_valid toggles every other cycle, one word.
    img[0] = 32'h1357_9BDF;
    load_image(16'h0001, 1, 1'b1, 1'b0);
    check("gap_we_latency", 64'(bus.mem_we), 64'd1);
    wait_idle();
    check("gap_done", 64'(done), 64'd1);
    check("gap_words", 64'(words_loaded), 64'd1);

    // Reset after 6 of 8 data bytes: first word written, second aborted.
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) sb.push_back('{addr: ADDR_W'(0), data: img[0]});
      send_byte(img[0][31-8*b -: 8], 1'b0);
    end
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_no_write", 64'(words_loaded), 64'd0);
    img[0] = 32'hCAFE_F00D;
    load_image(16'h0001, 1, 1'b0, 1'b0);
    wait_idle();
    check("after_reset_done", 64'(done), 64'd1);
    check("after_reset_addr", 64'(bus.mem_addr), 64'd0);
    check("after_reset_data", 64'(bus.mem_wdata), 64'hCAFE_F00D);

    // Full-depth random image with start pulses ignored mid-load.
    for (int w = 0; w < DEPTH; w++) img[w] = $urandom;
    load_image(16'(DEPTH), DEPTH, 1'b0, 1'b1);
    check("full_we_latency", 64'(bus.mem_we), 64'd1);
    wait_idle();
    check("full_done", 64'(done), 64'd1);
    check("full_err", 64'(err), 64'd0);
    check("full_words", 64'(words_loaded), 64'(DEPTH));
    check("full_last_addr", 64'(bus.mem_addr), 64'(DEPTH - 1));
    check("full_last_data", 64'(bus.mem_wdata), 64'(img[DEPTH-1]));
    hold_valid(11'(DEPTH));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
